// File: rtl/domain_exec_if.sv
// Instruction channel for domain_exec: valid/ready handshake plus opcode and operand fields.
interface domain_exec_if #(
  parameter int WIDTH = 8,
  parameter int NREGS = 64
);
  localparam int REGSEL_W = $clog2(NREGS);

  logic                in_valid;
  logic                in_ready;
  logic [3:0]          in_opcode;
  logic [REGSEL_W-1:0] in_rd;
  logic [REGSEL_W-1:0] in_rs0;
  logic [REGSEL_W-1:0] in_rs1;
  logic [WIDTH-1:0]    in_imm;

  modport master (output in_valid, in_opcode, in_rd, in_rs0, in_rs1, in_imm, input in_ready);
  modport slave  (input in_valid, in_opcode, in_rd, in_rs0, in_rs1, in_imm, output in_ready);
endinterface

// File: rtl/domain_exec.sv
// Single-issue execution domain: register bank, ALU and a five-state sequencer
// (IDLE -> RD0 -> RD1 -> EXEC -> WB) running one reg-to-reg instruction at a time.
module domain_exec #(
  parameter int WIDTH = 8,
  parameter int NREGS = 64,
  localparam int REGSEL_W = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  domain_exec_if.slave        req,
  output logic                done,
  output logic [WIDTH-1:0]    result,
  output logic                flag_z,
  output logic                flag_c,
  output logic                err,
  input  logic [REGSEL_W-1:0] dbg_sel,
  output logic [WIDTH-1:0]    dbg_val
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, EXEC, WB} state_t;

  typedef struct packed {
    logic [3:0]          opcode;
    logic [REGSEL_W-1:0] rd;
    logic [REGSEL_W-1:0] rs0;
    logic [REGSEL_W-1:0] rs1;
    logic [WIDTH-1:0]    imm;
  } instr_t;

  state_t           state;
  instr_t           ins;
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] op0, op1, alu_q;
  logic [WIDTH:0]   alu;
  logic             bad;

  assign dbg_val = regs[dbg_sel];

  // Bit WIDTH carries the carry/borrow/shift-out bit.
  always_comb begin
    alu = '0;
    bad = 1'b0;
    case (ins.opcode)
      4'd0:    alu = {1'b0, op0} + {1'b0, op1};
      4'd1:    alu = {1'b0, op0} - {1'b0, op1};
      4'd2:    alu = {1'b0, op0 & op1};
      4'd3:    alu = {1'b0, op0 | op1};
      4'd4:    alu = {1'b0, op0 ^ op1};
      4'd5:    alu = {op0, 1'b0};
      4'd6:    alu = {op0[0], 1'b0, op0[WIDTH-1:1]};
      4'd7:    alu = {1'b0, op0};
      4'd8:    alu = {1'b0, ins.imm};
      default: bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ins          <= '0;
      op0          <= '0;
      op1          <= '0;
      alu_q        <= '0;
      req.in_ready <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      result       <= '0;
      flag_z       <= 1'b0;
      flag_c       <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: if (req.in_valid) begin
          ins          <= '{req.in_opcode, req.in_rd, req.in_rs0, req.in_rs1, req.in_imm};
          req.in_ready <= 1'b0;
          state        <= RD0;
        end
        RD0: begin
          op0   <= regs[ins.rs0];
          state <= RD1;
        end
        RD1: begin
          op1   <= regs[ins.rs1];
          state <= EXEC;
        end
        // Result and flags are published on entry to WB so they are valid alongside done.
        EXEC: begin
          alu_q <= alu[WIDTH-1:0];
          done  <= 1'b1;
          err   <= bad;
          if (!bad) begin
            result <= alu[WIDTH-1:0];
            flag_z <= (alu[WIDTH-1:0] == '0);
            flag_c <= alu[WIDTH];
          end
          state <= WB;
        end
        WB: begin
          // regs[0] is never written, so it reads as zero forever.
          if (!err && ins.rd != '0) regs[ins.rd] <= alu_q;
          req.in_ready <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_domain_exec.sv
// Randomised + directed bench for domain_exec against an arithmetic reference model.
module tb_domain_exec;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  domain_exec_if #(.WIDTH(8), .NREGS(64)) bus ();
  logic       done, flag_z, flag_c, err;
  logic [7:0] result, dbg_val;
  logic [5:0] dbg_sel;

  domain_exec #(.WIDTH(8), .NREGS(64)) u_dut (
    .clk(clk), .reset(reset), .req(bus.slave), .done(done), .result(result),
    .flag_z(flag_z), .flag_c(flag_c), .err(err), .dbg_sel(dbg_sel), .dbg_val(dbg_val)
  );

  domain_exec_if #(.WIDTH(16), .NREGS(8)) bus16 ();
  logic        done16, flag_z16, flag_c16, err16;
  logic [15:0] result16, dbg_val16;
  logic [2:0]  dbg_sel16;

  domain_exec #(.WIDTH(16), .NREGS(8)) u_dut16 (
    .clk(clk), .reset(reset), .req(bus16.slave), .done(done16), .result(result16),
    .flag_z(flag_z16), .flag_c(flag_c16), .err(err16), .dbg_sel(dbg_sel16), .dbg_val(dbg_val16)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference state: register file plus the held result/flags.
  int m_regs [64];
  int m_res, m_z, m_c;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got %0h exp %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_regs[i] = 0;
    m_res = 0; m_z = 0; m_c = 0;
  endtask

  // Returns expected err; updates held result/flags and registers.
  function automatic int model_exec(input int op, input int rd, input int rs0, input int rs1, input int imm);
    int a, b, r, c;
    a = m_regs[rs0];
    b = m_regs[rs1];
    c = 0;
    case (op)
      0: begin r = (a + b) % 256; c = (a + b >= 256); end
      1: begin r = (a - b + 256) % 256; c = (a < b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = (a * 2) % 256; c = (a >= 128); end
      6: begin r = a / 2; c = a % 2; end
      7: r = a;
      8: r = imm;
      default: return 1;
    endcase
    m_res = r; m_c = c; m_z = (r == 0);
    if (rd != 0) m_regs[rd] = r;
    return 0;
  endfunction

  task automatic issue(input int op, input int rd, input int rs0, input int rs1, input int imm);
    int e;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_opcode = 4'(op); bus.in_rd = 6'(rd);
    bus.in_rs0 = 6'(rs0); bus.in_rs1 = 6'(rs1); bus.in_imm = 8'(imm);
    chk("ready_idle", 32'(bus.in_ready), 1);
    e = model_exec(op, rd, rs0, rs1, imm);
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        // Fields must be ignored after the handshake edge.
        bus.in_valid = 1'b0; bus.in_opcode = 4'($urandom); bus.in_rd = 6'($urandom);
        bus.in_rs0 = 6'($urandom); bus.in_rs1 = 6'($urandom); bus.in_imm = 8'($urandom);
      end
      if (k < 4) chk("busy_quiet", {29'd0, done, err, bus.in_ready}, 0);
      if (k == 4) begin
        chk("done", 32'(done), 1);
        chk("err", 32'(err), 32'(e));
        chk("ready_wb", 32'(bus.in_ready), 0);
        chk("result", 32'(result), 32'(m_res));
        chk("flags", {30'd0, flag_z, flag_c}, 32'({m_z[0], m_c[0]}));
      end
      if (k == 5) begin
        chk("post_wb", {30'd0, done, err}, 0);
        dbg_sel = 6'(rd);
        #1 chk("dbg_rd", 32'(dbg_val), 32'(m_regs[rd]));
      end
    end
  endtask

  task automatic issue16(input int op, input int rd, input int rs0, input int rs1,
                         input logic [15:0] imm, input logic [15:0] exp, input logic expc);
    @(negedge clk);
    bus16.in_valid = 1'b1; bus16.in_opcode = 4'(op); bus16.in_rd = 3'(rd);
    bus16.in_rs0 = 3'(rs0); bus16.in_rs1 = 3'(rs1); bus16.in_imm = imm;
    @(posedge clk);
    @(negedge clk);
    bus16.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("w16_done", 32'(done16), 1);
    chk("w16_result", 32'(result16), 32'(exp));
    chk("w16_c", 32'(flag_c16), 32'(expc));
    @(negedge clk);
    dbg_sel16 = 3'(rd);
    #1 chk("w16_dbg", 32'(dbg_val16), 32'(exp));
  endtask

  initial begin
    int acc [$];
    int op, rd, rs0, rs1, nacc, quiet;
    bus.in_valid = 0; bus.in_opcode = 0; bus.in_rd = 0; bus.in_rs0 = 0; bus.in_rs1 = 0; bus.in_imm = 0;
    bus16.in_valid = 0; bus16.in_opcode = 0; bus16.in_rd = 0; bus16.in_rs0 = 0; bus16.in_rs1 = 0; bus16.in_imm = 0;
    dbg_sel = 0; dbg_sel16 = 0;
    model_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_outs", {26'd0, bus.in_ready, done, err, flag_z, flag_c, 1'b0}, 32'b100000);
    chk("rst_result", 32'(result), 0);
    dbg_sel = 6'd37;
    #1 chk("rst_reg", 32'(dbg_val), 0);

    // Directed sequence
    issue(8, 1, 0, 0, 8'h7F);
    issue(8, 2, 0, 0, 8'h81);
    issue(0, 3, 1, 2, 0);
    issue(1, 4, 1, 2, 0);
    issue(1, 5, 2, 1, 0);
    issue(5, 6, 2, 0, 0);
    issue(6, 6, 6, 6, 0);
    issue(4, 7, 1, 1, 0);
    issue(8, 0, 0, 0, 8'h55);
    issue(12, 1, 2, 3, 8'hAA);
    dbg_sel = 6'd1;
    #1 chk("rsv_no_write", 32'(dbg_val), 8'h7F);
    issue(0, 8, 8, 8, 0);

    // Randomised instructions over a small register window to force reuse
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 9);
      if (op == 9) op = $urandom_range(9, 15);
      rd = $urandom_range(0, 15); rs0 = $urandom_range(0, 15); rs1 = $urandom_range(0, 15);
      issue(op, rd, rs0, rs1, $urandom_range(0, 255));
    end

    // Back-to-back: valid held high, ADD r10 = r10 + r11
    issue(8, 11, 0, 0, 8'h13);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_opcode = 4'd0; bus.in_rd = 6'd10; bus.in_rs0 = 6'd10; bus.in_rs1 = 6'd11;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 19) bus.in_valid = 1'b0;
      else if (bus.in_ready) acc.push_back(i);
    end
    repeat (6) @(negedge clk);
    nacc = acc.size();
    chk("b2b_count", 32'(nacc), 4);
    for (int i = 1; i < nacc; i++) chk("b2b_gap", 32'(acc[i] - acc[i-1]), 5);
    for (int i = 0; i < nacc; i++) void'(model_exec(0, 10, 10, 11, 0));
    dbg_sel = 6'd10;
    #1 chk("b2b_r10", 32'(dbg_val), 32'(m_regs[10]));

    // Reset while ADD r3 is in EXEC
    issue(8, 1, 0, 0, 8'h21);
    issue(8, 2, 0, 0, 8'h42);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_opcode = 4'd0; bus.in_rd = 6'd3; bus.in_rs0 = 6'd1; bus.in_rs1 = 6'd2;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1 chk("async_ready", 32'(bus.in_ready), 1);
    chk("async_done", 32'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    quiet = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) quiet = 0;
    end
    chk("abandon_nodone", 32'(quiet), 1);
    dbg_sel = 6'd3;
    #1 chk("abandon_r3", 32'(dbg_val), 0);
    issue(8, 9, 0, 0, 8'hC3);

    // Wide instance
    issue16(8, 1, 0, 0, 16'hFFFF, 16'hFFFF, 1'b0);
    issue16(0, 2, 1, 1, 16'h0000, 16'hFFFE, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
